// File: rtl/fp_pkg.sv
// Shared single-precision constants, word layout and accumulator state encoding.
package fp_pkg;

  localparam int         FP_EXP_W   = 8;
  localparam int         FP_MAN_W   = 23;
  localparam int         FP_BIAS    = 127;
  localparam logic [7:0] FP_EXP_MAX = 8'hFE;

  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] exp;
    logic [FP_MAN_W-1:0] man;
  } fp32_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_ADD,
    ST_NORM,
    ST_DONE
  } fp_acc_state_t;

endpackage

// File: rtl/fp_accumulator_if.sv
// Term input and sum output handshakes of the accumulator.
// The master drives terms and out_ready; the slave is the accumulator.
interface fp_accumulator_if #(
  parameter int N     = 32,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_data;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count
  );
endinterface

// File: rtl/fp_align_add.sv
// Combinational compare, align and add/subtract of two nonzero single-precision words.
// Truncates shifted-out bits; the result sign and exponent come from the larger operand.
module fp_align_add
  import fp_pkg::*;
(
  input  fp32_t       a_i,
  input  fp32_t       b_i,
  output logic [24:0] sum_o,
  output logic [8:0]  exp_o,
  output logic        sign_o
);

  logic        a_big;
  fp32_t       big_op;
  fp32_t       lit_op;
  logic [23:0] big_m;
  logic [23:0] lit_m;
  logic [23:0] lit_sh;
  logic [7:0]  diff;

  always_comb begin
    a_big  = (a_i.exp > b_i.exp) || ((a_i.exp == b_i.exp) && (a_i.man >= b_i.man));
    big_op = a_big ? a_i : b_i;
    lit_op = a_big ? b_i : a_i;
    big_m  = {1'b1, big_op.man};
    lit_m  = {1'b1, lit_op.man};
    diff   = big_op.exp - lit_op.exp;
    // Differences of 25 or more move the smaller operand entirely out of range.
    lit_sh = (diff >= 8'd25) ? 24'd0 : (lit_m >> diff);
    if (big_op.sign == lit_op.sign) begin
      sum_o = {1'b0, big_m} + {1'b0, lit_sh};
    end else begin
      sum_o = {1'b0, big_m} - {1'b0, lit_sh};
    end
    exp_o  = {1'b0, big_op.exp};
    sign_o = big_op.sign;
  end

endmodule

// File: rtl/fp_accumulator.sv
// Sequential single-precision accumulator: sums handshaked terms, emits the total after in_last.
// Optional macro FP_ACC_SAT_EN clamps exponent overflow to the largest finite magnitude.
module fp_accumulator
  import fp_pkg::*;
#(
  parameter int N     = 32,
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  fp_accumulator_if.slave acc_if
);

  fp_acc_state_t    state_q, state_d;
  fp32_t            acc_q, acc_d;
  logic [N-1:0]     term_q, term_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic [24:0]      sum_q, sum_d;
  logic [8:0]       wexp_q, wexp_d;
  logic             sign_q, sign_d;
  logic             sat_q, sat_d;

  logic [24:0] aa_sum;
  logic [8:0]  aa_exp;
  logic        aa_sign;
  logic        accept;
  logic        commit;
  logic        zero_res;
  logic [8:0]  c_exp;
  logic [22:0] c_man;

  // acc_q and term_q stay stable through ALIGN and ADD, giving this path two cycles.
  fp_align_add u_align_add (
    .a_i    (acc_q),
    .b_i    (fp32_t'(term_q)),
    .sum_o  (aa_sum),
    .exp_o  (aa_exp),
    .sign_o (aa_sign)
  );

  assign accept           = acc_if.in_valid && (state_q == ST_IDLE);
  assign acc_if.in_ready  = (state_q == ST_IDLE);
  assign acc_if.out_valid = (state_q == ST_DONE);
  assign acc_if.out_data  = acc_q;
  assign acc_if.out_count = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      term_q <= '0;
      cnt_q  <= '0;
      last_q <= 1'b0;
      sum_q  <= '0;
      wexp_q <= '0;
      sign_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      term_q <= term_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
      sum_q  <= sum_d;
      wexp_q <= wexp_d;
      sign_q <= sign_d;
      sat_q  <= sat_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    term_d   = term_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    sum_d    = sum_q;
    wexp_d   = wexp_q;
    sign_d   = sign_q;
    sat_d    = sat_q;
    commit   = 1'b0;
    zero_res = 1'b0;
    c_exp    = wexp_q;
    c_man    = sum_q[22:0];

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cnt_d  = cnt_q + 1'b1;
          last_d = acc_if.in_last;
          term_d = acc_if.in_data;
          if ((acc_if.in_data == '0) || sat_q) begin
            state_d = acc_if.in_last ? ST_DONE : ST_IDLE;
          end else if (acc_q == '0) begin
            acc_d   = fp32_t'(acc_if.in_data);
            state_d = acc_if.in_last ? ST_DONE : ST_IDLE;
          end else begin
            state_d = ST_ALIGN;
          end
        end
      end

      ST_ALIGN: state_d = ST_ADD;

      ST_ADD: begin
        sum_d   = aa_sum;
        wexp_d  = aa_exp;
        sign_d  = aa_sign;
        state_d = ST_NORM;
      end

      ST_NORM: begin
        if (sum_q[24]) begin
          commit = 1'b1;
          c_exp  = wexp_q + 9'd1;
          c_man  = sum_q[23:1];
        end else if (sum_q == '0) begin
          commit   = 1'b1;
          zero_res = 1'b1;
        end else if (sum_q[23]) begin
          commit = 1'b1;
        end else if (wexp_q <= 9'd1) begin
          commit   = 1'b1;
          zero_res = 1'b1;
        end else begin
          sum_d  = sum_q << 1;
          wexp_d = wexp_q - 9'd1;
        end

        if (commit) begin
          if (zero_res) begin
            acc_d = '0;
          end else begin
            acc_d = {sign_q, c_exp[7:0], c_man};
`ifdef FP_ACC_SAT_EN
            if (c_exp >= 9'd255) begin
              acc_d = {sign_q, FP_EXP_MAX, 23'h7FFFFF};
              sat_d = 1'b1;
            end
`endif
          end
          state_d = last_q ? ST_DONE : ST_IDLE;
        end
      end

      ST_DONE: begin
        if (acc_if.out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fp_accumulator.sv
// Scoreboard bench for fp_accumulator: expected sums queued at the last term, checked at the output.
`timescale 1ns/1ps
module tb_fp_accumulator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  fp_accumulator_if #(.N(32), .CNT_W(8)) bus ();

  fp_accumulator #(.N(32), .CNT_W(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .acc_if (bus)
  );

  typedef struct {
    logic [31:0] data;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [31:0] c);
    exp_t e;
    e.data = d;
    e.cnt  = c;
    sb.push_back(e);
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int n = 0;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", {31'b0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = $urandom;
    bus.in_last  = 1'b0;
  endtask

  task automatic recv(input int hold);
    int          n = 0;
    logic [31:0] d0;
    exp_t        e;
    bus.out_ready = 1'b0;
    while (!bus.out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("out_valid_wait", {31'b0, bus.out_valid}, 32'd1);
    d0 = bus.out_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", {31'b0, bus.out_valid}, 32'd1);
      check("hold_data", bus.out_data, d0);
    end
    check("sb_pending", sb.size(), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("out_data", bus.out_data, e.data);
      check("out_count", {24'b0, bus.out_count}, e.cnt);
      $display("sum: data=0x%08h count=%0d (expected 0x%08h / %0d)",
               bus.out_data, bus.out_count, e.data, e.cnt);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("post_valid", {31'b0, bus.out_valid}, 32'd0);
    check("post_count", {24'b0, bus.out_count}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic low_ok;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    check("rst_out_count", {24'b0, bus.out_count}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1.0 + 2.0 = 3.0
    send(32'h3F800000, 1'b0);
    send(32'h40000000, 1'b1);
    push_exp(32'h40400000, 32'd2);
    recv(0);

    // 1.5 + -1.5 cancels exactly
    send(32'h3FC00000, 1'b0);
    send(32'hBFC00000, 1'b1);
    push_exp(32'h00000000, 32'd2);
    recv(0);

    // Exponent gap of 30: small term vanishes
    send(32'h3F800000, 1'b0);
    send(32'h30800000, 1'b1);
    push_exp(32'h3F800000, 32'd2);
    recv(1);

    // 1.0 - 0.99999994 needs 23 left shifts; also 5 cycles of back-pressure
    send(32'h3F800000, 1'b0);
    check("trivial_ready", {31'b0, bus.in_ready}, 32'd1);
    send(32'hBF7FFFFF, 1'b1);
    push_exp(32'h34000000, 32'd2);
    n = 0;
    low_ok = 1'b1;
    while (!bus.out_valid && n < 100) begin
      if (bus.in_ready) low_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    check("norm_latency", n, 32'd26);
    check("ready_low", {31'b0, low_ok}, 32'd1);
    recv(5);

    // Exponent overflow
    send(32'h7F000000, 1'b0);
    send(32'h7F000000, 1'b1);
`ifdef FP_ACC_SAT_EN
    push_exp(32'h7F7FFFFF, 32'd2);
`else
    push_exp(32'h7F800000, 32'd2);
`endif
    recv(0);

    // Zero term leaves acc empty; trivial last term reaches DONE immediately
    send(32'h00000000, 1'b0);
    send(32'h3F800000, 1'b1);
    check("trivial_last_valid", {31'b0, bus.out_valid}, 32'd1);
    push_exp(32'h3F800000, 32'd2);
    recv(0);

    // Three terms: 1 + 1 + 1 = 3
    send(32'h3F800000, 1'b0);
    send(32'h3F800000, 1'b0);
    send(32'h3F800000, 1'b1);
    push_exp(32'h40400000, 32'd3);
    recv(0);

    // 3.0 - 1.0 = 2.0
    send(32'h40400000, 1'b0);
    send(32'hBF800000, 1'b1);
    push_exp(32'h40000000, 32'd2);
    recv(0);

    // Reset pulse during NORM discards the partial sum
    send(32'h3F800000, 1'b0);
    send(32'hBF7FFFFF, 1'b1);
    repeat (5) @(negedge clk);
    check("norm_ready_low", {31'b0, bus.in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("mid_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("mid_rst_out_data", bus.out_data, 32'd0);
    check("mid_rst_out_count", {24'b0, bus.out_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(32'h3F800000, 1'b0);
    send(32'h40000000, 1'b1);
    push_exp(32'h40400000, 32'd2);
    recv(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
